// File: rtl/i2s_rx_deserializer.sv
// Philips I2S receiver: synchronizes BCK/LCK/DIN into the clk domain,
// deserializes left/right slots and presents each pair on valid/ready.
// Ports:
//   clk, rst              system clock, synchronous active-high reset
//   bck, lck, din         asynchronous I2S lines
//   out_left, out_right   MSB-aligned two's-complement samples
//   out_valid, out_ready  pair handshake
//   locked                frame alignment acquired (first 1->0 LCK edge)
//   overrun               sticky: a completed pair was dropped
module i2s_rx_deserializer #(
  parameter int unsigned SAMPLE_WIDTH = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    bck,
  input  logic                    lck,
  input  logic                    din,
  output logic [SAMPLE_WIDTH-1:0] out_left,
  output logic [SAMPLE_WIDTH-1:0] out_right,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    locked,
  output logic                    overrun
);

  localparam int unsigned CNT_W = $clog2(SAMPLE_WIDTH + 1);

  typedef enum logic [1:0] {SYNC, LEFT, RIGHT} state_t;

  state_t                  state;
  logic                    bck_m, bck_s, bck_d;
  logic                    lck_m, lck_s;
  logic                    din_m, din_s;
  logic                    lck_prev, lck_prev_ok;
  logic [SAMPLE_WIDTH-1:0] sr;
  logic [SAMPLE_WIDTH-1:0] left_hold;
  logic [CNT_W-1:0]        cnt;
  logic [SAMPLE_WIDTH-1:0] word;
  logic                    bck_rise;
  logic                    slot_end;
  logic                    cnt_room;
  logic                    pair_done;

  // Two-flop synchronizers plus one extra bck stage for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      bck_m <= 1'b0; bck_s <= 1'b0; bck_d <= 1'b0;
      lck_m <= 1'b0; lck_s <= 1'b0;
      din_m <= 1'b0; din_s <= 1'b0;
    end else begin
      bck_m <= bck;  bck_s <= bck_m; bck_d <= bck_s;
      lck_m <= lck;  lck_s <= lck_m;
      din_m <= din;  din_s <= din_m;
    end
  end

  assign bck_rise  = bck_s & ~bck_d;
  assign slot_end  = (lck_s != lck_prev);
  assign cnt_room  = (cnt < CNT_W'(SAMPLE_WIDTH));
  assign pair_done = bck_rise && lck_prev_ok && (state == RIGHT) && slot_end;

  // Shift register with the current bit merged; bits past the word width are dropped.
  always_comb begin
    word = sr;
    for (int i = 0; i < int'(SAMPLE_WIDTH); i++) begin
      if (cnt_room && (i == int'(SAMPLE_WIDTH) - 1 - int'(cnt))) word[i] = din_s;
    end
  end

  // Frame FSM, bit capture and output handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= SYNC;
      lck_prev    <= 1'b0;
      lck_prev_ok <= 1'b0;
      sr          <= '0;
      cnt         <= '0;
      left_hold   <= '0;
      out_left    <= '0;
      out_right   <= '0;
      out_valid   <= 1'b0;
      locked      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (bck_rise) begin
        if (!lck_prev_ok) begin
          lck_prev    <= lck_s;
          lck_prev_ok <= 1'b1;
        end else begin
          case (state)
            SYNC: begin
              lck_prev <= lck_s;
              if (lck_prev && !lck_s) begin
                state  <= LEFT;
                locked <= 1'b1;
                sr     <= '0;
                cnt    <= '0;
              end
            end
            LEFT, RIGHT: begin
              if (slot_end) begin
                sr       <= '0;
                cnt      <= '0;
                lck_prev <= lck_s;
                if (state == LEFT) begin
                  left_hold <= word;
                  state     <= RIGHT;
                end else begin
                  state <= LEFT;
                end
              end else if (cnt_room) begin
                sr  <= word;
                cnt <= cnt + CNT_W'(1);
              end
            end
            default: state <= SYNC;
          endcase
        end
      end

      // A new pair replaces the held one only if the held one leaves this cycle.
      if (pair_done) begin
        if (!out_valid || out_ready) begin
          out_left  <= left_hold;
          out_right <= word;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
module tb_i2s_rx_deserializer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bck = 1'b0;
  logic        lck = 1'b1;
  logic        din = 1'b0;
  logic        out_ready = 1'b1;
  logic [23:0] out_left, out_right;
  logic        out_valid, locked, overrun;

  int checks = 0;
  int errors = 0;

  logic [47:0] pairs [$];
  int          valid_cycles = 0;
  int          rd = 0;
  int          vc0;
  logic [23:0] exp_l [64];
  logic [23:0] exp_r [64];

  i2s_rx_deserializer #(.SAMPLE_WIDTH(24)) dut (
    .clk(clk), .rst(rst), .bck(bck), .lck(lck), .din(din),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .locked(locked), .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Records every accepted pair and every cycle out_valid is high.
  always @(negedge clk) begin
    if (out_valid) begin
      valid_cycles <= valid_cycles + 1;
      if (out_ready) pairs.push_back({out_left, out_right});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One BCK period; data/LCK change on the falling edge, din glitches while BCK is high.
  task automatic send_bit(input logic l, input logic d, input int h);
    lck = l;
    din = d;
    bck = 1'b0;
    tick(h);
    bck = 1'b1;
    if (h >= 4) begin
      tick(2);
      din = ~d;
      tick(h - 2);
    end else begin
      tick(h);
    end
  endtask

  // Slot words are right-justified in s bits, MSB sent first; LCK leads by one bit.
  task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int s, input int h);
    for (int i = 0; i < s; i++) send_bit(i == s - 1, l[s-1-i], h);
    for (int i = 0; i < s; i++) send_bit(i != s - 1, r[s-1-i], h);
  endtask

  task automatic preamble(input int h);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b1, h);
    send_bit(1'b0, 1'b0, h);
  endtask

  initial begin
    tick(4);
    rst = 1'b0;
    tick(2);
    check("rst_left",    64'(out_left),  64'h0);
    check("rst_right",   64'(out_right), 64'h0);
    check("rst_valid",   64'(out_valid), 64'h0);
    check("rst_locked",  64'(locked),    64'h0);
    check("rst_overrun", 64'(overrun),   64'h0);

    // 32-bit slots, 24-bit samples: low 8 slot bits truncated.
    preamble(4);
    check("t1_locked", 64'(locked), 64'h1);
    vc0 = valid_cycles;
    for (int f = 0; f < 3; f++) send_frame(32'hABCDEF5A, 32'h123456C3, 32, 4);
    tick(8);
    check("t1_count", 64'(pairs.size() - rd), 64'd3);
    check("t1_pulse", 64'(valid_cycles - vc0), 64'd3);
    for (int f = 0; f < 3; f++) begin
      check("t1_pair", 64'(pairs[rd]), 64'h000ABCDEF123456);
      rd++;
    end
    check("t1_overrun", 64'(overrun), 64'h0);

    // 16-bit slots zero-padded in the LSBs.
    send_frame(32'h00008001, 32'h00007FFF, 16, 4);
    tick(8);
    check("t2_count", 64'(pairs.size() - rd), 64'd1);
    check("t2_pair",  64'(pairs[rd]), 64'h0008001007FFF00);
    rd++;

    // Minimum clock ratio, back-to-back random frames.
    for (int f = 0; f < 64; f++) begin
      exp_l[f] = 24'($urandom);
      exp_r[f] = 24'($urandom);
      send_frame({exp_l[f], 8'($urandom)}, {exp_r[f], 8'($urandom)}, 32, 2);
    end
    tick(8);
    check("t6_count", 64'(pairs.size() - rd), 64'd64);
    for (int f = 0; f < 64; f++) begin
      check("t6_pair", 64'(pairs[rd]), 64'({exp_l[f], exp_r[f]}));
      rd++;
    end
    check("t6_overrun", 64'(overrun), 64'h0);

    // Backpressure: first pair held, later pairs dropped.
    out_ready = 1'b0;
    send_frame(32'h00000100, 32'hA0000100, 32, 4);
    tick(8);
    check("t3_valid1",   64'(out_valid), 64'h1);
    check("t3_left1",    64'(out_left),  64'h000001);
    check("t3_overrun1", 64'(overrun),   64'h0);
    send_frame(32'h00000200, 32'hA0000200, 32, 4);
    tick(8);
    check("t3_overrun2", 64'(overrun),   64'h1);
    check("t3_left2",    64'(out_left),  64'h000001);
    send_frame(32'h00000300, 32'hA0000300, 32, 4);
    tick(8);
    check("t3_left3",    64'(out_left),  64'h000001);
    check("t3_right3",   64'(out_right), 64'hA00001);
    out_ready = 1'b1;
    tick(3);
    check("t3_valid_drop", 64'(out_valid), 64'h0);
    check("t3_xfer_count", 64'(pairs.size() - rd), 64'd1);
    check("t3_xfer_pair",  64'(pairs[rd]), 64'h000001A00001);
    rd++;
    send_frame(32'h00000400, 32'hA0000400, 32, 4);
    tick(8);
    check("t3_count4",   64'(pairs.size() - rd), 64'd1);
    check("t3_pair4",    64'(pairs[rd]), 64'h000004A00004);
    rd++;
    check("t3_overrun4", 64'(overrun), 64'h1);

    // Reset in the middle of a left slot, then restart mid right slot.
    for (int i = 0; i < 10; i++) send_bit(1'b0, 1'b1, 4);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_left",    64'(out_left),  64'h0);
    check("t5_right",   64'(out_right), 64'h0);
    check("t5_valid",   64'(out_valid), 64'h0);
    check("t5_locked",  64'(locked),    64'h0);
    check("t5_overrun", 64'(overrun),   64'h0);
    for (int i = 0; i < 21; i++) send_bit(1'b0, 1'b1, 4);
    for (int i = 0; i < 20; i++) send_bit(1'b1, 1'($urandom), 4);
    tick(8);
    check("t4_locked_pre", 64'(locked), 64'h0);
    check("t4_no_pair",    64'(pairs.size() - rd), 64'd0);
    send_bit(1'b0, 1'b0, 4);
    check("t4_locked", 64'(locked), 64'h1);
    check("t4_no_pair2", 64'(pairs.size() - rd), 64'd0);
    send_frame(32'h5A5A5A00, 32'hC3C3C300, 32, 4);
    tick(8);
    check("t5_count", 64'(pairs.size() - rd), 64'd1);
    check("t5_pair",  64'(pairs[rd]), 64'h5A5A5AC3C3C3);
    rd++;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
